sdff_scan_ctrl: RTL

- Sequences a chain of scan flip-flops (sdffrsnq family) through shift, capture and unload.
- Drives chain SE, SI and a chain clock-enable; samples the chain's serial output SO.
- Test patterns arrive as a valid/ready bit stream; responses leave the same way.
- Sits between the on-chip test access logic and one scan chain of up to MAX_LEN cells.

---
 rtl/sdff_scan_pkg.sv | 18 +
 rtl/sdff_scan_ctrl_cnt.sv | 32 +++
 rtl/sdff_scan_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sdff_scan_pkg.sv
// Shared types for the scan-chain controller.
// State encoding, counter-width helper, default pattern-counter width.
package sdff_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_FLUSH
  } state_e;

  localparam int PCNT_W_DEF = 16;

  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sdff_scan_ctrl_cnt.sv
// Loadable down-counter with decrement enable and zero flag.
// Ports: clk_i, rst_i, ld_i, ld_val_i, dec_i -> zero_o.
module sdff_scan_ctrl_cnt #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)
      cnt_d = ld_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdff_scan_ctrl.sv
// Scan-chain sequencer: shift / capture / unload of one sdff chain.
// Ports: START/LEN/MORE/ABORT control, SIN/SOUT streams, SE/SI/CHAIN_CE/SO chain, status.
module sdff_scan_ctrl
  import sdff_scan_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = cnt_width(MAX_LEN),
  parameter int PCNT_W  = PCNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [CNT_W-1:0]  LEN,
  input  logic              MORE,
  input  logic              ABORT,
  input  logic              SIN_VALID,
  input  logic              SIN_DATA,
  output logic              SIN_READY,
  output logic              SOUT_VALID,
  output logic              SOUT_DATA,
  input  logic              SOUT_READY,
  input  logic              SO,
  output logic              SE,
  output logic              SI,
  output logic              CHAIN_CE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [PCNT_W-1:0] PAT_CNT
);

  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);

  state_e             state_q;
  logic [CNT_W-1:0]   len_q;
  logic               have_cap_q;
  logic               done_q;
  logic               err_q;
  logic [PCNT_W-1:0]  pcnt_q;

  logic in_shift, in_flush, in_cap, in_scan;
  logic in_ok, out_ok, fire;
  logic len_ok, start_ok, cap_go;
  logic cnt_ld, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;

  assign in_shift = (state_q == S_SHIFT);
  assign in_flush = (state_q == S_FLUSH);
  assign in_cap   = (state_q == S_CAPTURE);
  assign in_scan  = in_shift | in_flush;

  assign in_ok  = in_shift ? SIN_VALID : in_flush;
  assign out_ok = !have_cap_q || SOUT_READY;
  assign fire   = in_scan && in_ok && out_ok && !ABORT;
  assign cap_go = in_cap && !ABORT;

  assign len_ok   = (LEN != '0) && (LEN <= MAX_L);
  assign start_ok = (state_q == S_IDLE) && START && !ABORT;

  // Shift count is loaded for the first phase at START and
  // re-armed for every phase following a capture.
  assign cnt_ld     = (start_ok && len_ok) || cap_go;
  assign cnt_ld_val = in_cap ? len_q - 1'b1 : LEN - 1'b1;

  sdff_scan_ctrl_cnt #(.W(CNT_W)) u_cnt (
    .clk_i    (CLK),
    .rst_i    (RST),
    .ld_i     (cnt_ld),
    .ld_val_i (cnt_ld_val),
    .dec_i    (fire),
    .zero_o   (cnt_zero)
  );

  assign SE         = in_scan;
  assign BUSY       = (state_q != S_IDLE);
  assign CHAIN_CE   = fire | cap_go;
  assign SIN_READY  = in_shift && out_ok;
  assign SOUT_VALID = have_cap_q && in_scan && in_ok;
  assign SOUT_DATA  = SO;
  assign SI         = in_shift & SIN_DATA;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign PAT_CNT    = pcnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      have_cap_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pcnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (ABORT && state_q != S_IDLE) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_ok) begin
              if (len_ok) begin
                len_q      <= LEN;
                err_q      <= 1'b0;
                pcnt_q     <= '0;
                have_cap_q <= 1'b0;
                state_q    <= S_SHIFT;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_SHIFT: begin
            if (fire && cnt_zero) state_q <= S_CAPTURE;
          end
          S_CAPTURE: begin
            have_cap_q <= 1'b1;
            if (pcnt_q != '1) pcnt_q <= pcnt_q + 1'b1;
            state_q <= MORE ? S_SHIFT : S_FLUSH;
          end
          S_FLUSH: begin
            if (fire && cnt_zero) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
